// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pkg
//  Description : Shared definitions for the SD CMD-line engine: FSM state
//                encoding, response-type codes, CRC7 polynomial, frame length
//                and the serial CRC7 step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_RESP = 3'd2,
    ST_RECV      = 3'd3,
    ST_NRC       = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [1:0] RESP_NONE = 2'd0;  // no response expected
  localparam logic [1:0] RESP_R1   = 2'd1;  // R1/R6/R7, CRC checked
  localparam logic [1:0] RESP_R3   = 2'd2;  // R3, CRC field ignored
  localparam logic [1:0] RESP_RSVD = 2'd3;  // reserved, behaves as RESP_NONE

  // x^7 + x^3 + 1 (the x^7 term is implicit in the feedback)
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int FRAME_LEN = 48;

  // One serial CRC7 update, MSB-first data.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

  // True when the latched response type makes the engine listen for a reply.
  function automatic logic resp_expected(input logic [1:0] rtype);
    case (rtype)
      RESP_R1, RESP_R3:     return 1'b1;
      RESP_NONE, RESP_RSVD: return 1'b0;
      default:              return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
//  Module      : sd_crc7
//  Description : Serial CRC7 generator/checker (x^7+x^3+1, init 0).
//  Ports       : clk    - system clock
//                resetn - asynchronous active-low reset
//                clear  - synchronous clear to 0 (priority over en)
//                en     - shift one data bit in
//                din    - data bit, MSB first
//                crc    - current CRC7 remainder
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_cmd_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sd_cmd_engine
//  Description : SD CMD-line engine. Serialises a 48-bit command frame with
//                generated CRC7, optionally receives a 48-bit response and
//                checks its framing/CRC7, then idles NRC_TICKS SD clocks and
//                pulses done. All line activity advances on sd_clk_en strobes.
//  Ports       : clk, resetn            - clock, async active-low reset
//                sd_clk_en              - one-clk strobe per SD clock period
//                cmd_start              - start request (taken when busy=0)
//                cmd_index, cmd_arg     - command index / argument
//                resp_type              - 0 none, 1 R1/R6/R7, 2 R3, 3 = none
//                busy, done             - transaction status / end pulse
//                resp_index, resp_arg   - received response fields
//                crc_err, timeout       - response error flags
//                cmd_out, cmd_oe, cmd_in- CMD pad drive, enable, sample
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int NRC_TICKS    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sd_clk_en,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  resp_type,
  output logic        busy,
  output logic        done,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        crc_err,
  output logic        timeout,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic        cmd_in
);

  localparam int WAIT_W = $clog2(RESP_TIMEOUT + 1);
  localparam int NRC_W  = $clog2(NRC_TICKS + 1);

  localparam logic [5:0] TX_LAST     = 6'(FRAME_LEN - 1);  // end bit of command
  localparam logic [5:0] CRC_FIRST   = 6'(FRAME_LEN - 8);  // first CRC bit position
  localparam logic [5:0] RX_LAST     = 6'(FRAME_LEN - 2);  // end bit, start bit excluded
  localparam logic [5:0] RX_CRC_BITS = 6'(FRAME_LEN - 9);  // covered bits after start bit

  state_t state, next_state;

  logic [39:0]       tx_shift;    // start, transmission, index, arg
  logic [1:0]        rtype;
  logic [5:0]        bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic [NRC_W-1:0]  nrc_cnt;
  logic [45:0]       rx_shift;
  logic [46:0]       rx_frame;
  logic [6:0]        tx_crc;
  logic [6:0]        rx_crc;
  logic [2:0]        crc_sel;
  logic              tx_bit;
  logic              rx_err;
  logic              accept;
  logic              tx_crc_en;
  logic              rx_crc_en;

  // --------------------------------------------------------------------------
  // CRC units: TX covers the 40 outgoing header bits; RX covers the 39 bits
  // after the start bit (a leading 0 leaves a zero-initialised CRC7 unchanged,
  // so the start bit need not be fed).
  // --------------------------------------------------------------------------
  assign tx_crc_en = (state == ST_SEND) && sd_clk_en && (bit_cnt < CRC_FIRST);
  assign rx_crc_en = (state == ST_RECV) && sd_clk_en && (bit_cnt < RX_CRC_BITS);

  sd_crc7 u_tx_crc (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept),
    .en     (tx_crc_en),
    .din    (tx_shift[39]),
    .crc    (tx_crc)
  );

  sd_crc7 u_rx_crc (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept),
    .en     (rx_crc_en),
    .din    (cmd_in),
    .crc    (rx_crc)
  );

  // Outgoing bit for the current position: header, then CRC MSB-first, then end bit.
  assign crc_sel = 3'(TX_LAST - 6'd1 - bit_cnt);
  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt < CRC_FIRST) begin
      tx_bit = tx_shift[39];
    end else if (bit_cnt < TX_LAST) begin
      tx_bit = tx_crc[crc_sel];
    end
  end

  // Response after the start bit, including the bit sampled this strobe:
  // [46] transmission, [45:40] index, [39:8] arg, [7:1] CRC7, [0] end.
  assign rx_frame = {rx_shift, cmd_in};
  assign rx_err   = rx_frame[46] || !rx_frame[0] ||
                    ((rtype == RESP_R1) && (rx_frame[7:1] != rx_crc));

  assign wait_cnt_inc = wait_cnt + 1'b1;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = cmd_start;
        if (cmd_start) next_state = ST_SEND;
      end
      ST_SEND: begin
        busy = 1'b1;
        if (sd_clk_en && (bit_cnt == TX_LAST)) begin
          next_state = resp_expected(rtype) ? ST_WAIT_RESP : ST_NRC;
        end
      end
      ST_WAIT_RESP: begin
        busy = 1'b1;
        if (sd_clk_en) begin
          // A start bit on the final count still wins over the timeout.
          if (!cmd_in) begin
            next_state = ST_RECV;
          end else if (wait_cnt_inc == WAIT_W'(RESP_TIMEOUT)) begin
            next_state = ST_NRC;
          end
        end
      end
      ST_RECV: begin
        busy = 1'b1;
        if (sd_clk_en && (bit_cnt == RX_LAST)) next_state = ST_NRC;
      end
      ST_NRC: begin
        busy = 1'b1;
        if (sd_clk_en && (nrc_cnt == NRC_W'(NRC_TICKS - 1))) next_state = ST_DONE;
      end
      ST_DONE: begin
        // busy is already low here, so a new request is taken straight away.
        done       = 1'b1;
        accept     = cmd_start;
        next_state = cmd_start ? ST_SEND : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: everything on the line side moves only on strobes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_shift   <= '0;
      rtype      <= RESP_NONE;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      nrc_cnt    <= '0;
      rx_shift   <= '0;
      resp_index <= '0;
      resp_arg   <= '0;
      crc_err    <= 1'b0;
      timeout    <= 1'b0;
      cmd_out    <= 1'b1;
      cmd_oe     <= 1'b0;
    end else if (accept) begin
      tx_shift <= {2'b01, cmd_index, cmd_arg};
      rtype    <= resp_type;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      nrc_cnt  <= '0;
      crc_err  <= 1'b0;
      timeout  <= 1'b0;
    end else if (sd_clk_en) begin
      case (state)
        ST_SEND: begin
          cmd_out <= tx_bit;
          cmd_oe  <= 1'b1;
          if (bit_cnt < CRC_FIRST) tx_shift <= {tx_shift[38:0], 1'b0};
          bit_cnt <= (bit_cnt == TX_LAST) ? 6'd0 : bit_cnt + 6'd1;
        end
        ST_WAIT_RESP: begin
          cmd_out  <= 1'b1;
          cmd_oe   <= 1'b0;
          wait_cnt <= wait_cnt_inc;
          if (cmd_in && (wait_cnt_inc == WAIT_W'(RESP_TIMEOUT))) timeout <= 1'b1;
        end
        ST_RECV: begin
          rx_shift <= rx_frame[45:0];
          if (bit_cnt == RX_LAST) begin
            bit_cnt    <= 6'd0;
            resp_index <= rx_frame[45:40];
            resp_arg   <= rx_frame[39:8];
            crc_err    <= rx_err;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        ST_NRC: begin
          cmd_out <= 1'b1;
          cmd_oe  <= 1'b0;
          nrc_cnt <= nrc_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
